// File: rtl/c7bifu_ibuf.sv
// c7b IFU instruction buffer: circular FIFO of {excp, pc, inst} between fetch return and decode.
// Define C7BIFU_IBUF_BYPASS_EN to forward fetch straight to decode when the buffer is empty.
module c7bifu_ibuf #(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            fetch_vld,
  input  logic [31:0]     fetch_inst,
  input  logic [31:0]     fetch_pc,
  input  logic            fetch_excp,
  output logic            fetch_rdy,
  output logic            de_vld,
  output logic [31:0]     de_inst,
  output logic [31:0]     de_pc,
  output logic            de_excp,
  input  logic            de_rdy,
  output logic [CNTW-1:0] ibuf_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     inst_d [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [31:0]     pc_d   [DEPTH];
  logic            excp_q [DEPTH];
  logic            excp_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic empty_s, full_s, byp_s, enq_s, deq_s;

  // State registers; reset clears pointers, count and every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= 32'h0;
        pc_q[i]   <= 32'h0;
        excp_q[i] <= 1'b0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      inst_q <= inst_d;
      pc_q   <= pc_d;
      excp_q <= excp_d;
    end
  end

  // Handshake and head-of-queue presentation.
  always_comb begin
    empty_s   = (cnt_q == '0);
    full_s    = (cnt_q == CNTW'(DEPTH));
    fetch_rdy = !full_s;
    byp_s     = 1'b0;
`ifdef C7BIFU_IBUF_BYPASS_EN
    byp_s     = empty_s & fetch_vld & !flush;
`endif
    de_vld    = byp_s | (!empty_s & !flush);
    if (byp_s) begin
      de_inst = fetch_inst;
      de_pc   = fetch_pc;
      de_excp = fetch_excp;
    end else if (!empty_s) begin
      de_inst = inst_q[rptr_q];
      de_pc   = pc_q[rptr_q];
      de_excp = excp_q[rptr_q];
    end else begin
      de_inst = 32'h0;
      de_pc   = 32'h0;
      de_excp = 1'b0;
    end
    // A bypassed instruction consumed this cycle never touches storage.
    enq_s = fetch_vld & !full_s & !flush & !(byp_s & de_rdy);
    deq_s = de_vld & de_rdy & !byp_s;
  end

  // Next-state: entry write, pointer advance, occupancy; flush wins over everything.
  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    excp_d = excp_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (enq_s) begin
      inst_d[wptr_q] = fetch_inst;
      pc_d[wptr_q]   = fetch_pc;
      excp_d[wptr_q] = fetch_excp;
      wptr_d         = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (deq_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({enq_s, deq_s})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  assign ibuf_cnt = cnt_q;

endmodule

// File: tb/tb_c7bifu_ibuf.sv
// Directed bench for c7bifu_ibuf with a queue scoreboard of expected head entries.
module tb_c7bifu_ibuf;

  localparam int DEPTH = 4;
  localparam int CNTW  = 3;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            fetch_vld;
  logic [31:0]     fetch_inst;
  logic [31:0]     fetch_pc;
  logic            fetch_excp;
  logic            fetch_rdy;
  logic            de_vld;
  logic [31:0]     de_inst;
  logic [31:0]     de_pc;
  logic            de_excp;
  logic            de_rdy;
  logic [CNTW-1:0] ibuf_cnt;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  logic [64:0] sb[$];

  c7bifu_ibuf #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_vld(fetch_vld), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_excp(fetch_excp), .fetch_rdy(fetch_rdy),
    .de_vld(de_vld), .de_inst(de_inst), .de_pc(de_pc), .de_excp(de_excp),
    .de_rdy(de_rdy), .ibuf_cnt(ibuf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model, move past the rising edge.
  task automatic step(input logic fv, input logic [31:0] fi, input logic [31:0] fp,
                      input logic fe, input logic dr, input logic fl);
    logic exp_rdy, exp_vld, byp, enq, deq;
    logic [64:0] head;
    fetch_vld = fv; fetch_inst = fi; fetch_pc = fp; fetch_excp = fe; de_rdy = dr; flush = fl;
    @(negedge clk);
    exp_rdy = (mcnt != DEPTH);
    byp = 1'b0;
`ifdef C7BIFU_IBUF_BYPASS_EN
    byp = (mcnt == 0) && fv && !fl;
`endif
    exp_vld = byp || ((mcnt != 0) && !fl);
    check("fetch_rdy", 64'(fetch_rdy), 64'(exp_rdy));
    check("ibuf_cnt", 64'(ibuf_cnt), 64'(mcnt));
    check("de_vld", 64'(de_vld), 64'(exp_vld));
    if (exp_vld) begin
      head = byp ? {fe, fp, fi} : sb[0];
      check("de_inst", 64'(de_inst), 64'(head[31:0]));
      check("de_pc", 64'(de_pc), 64'(head[63:32]));
      check("de_excp", 64'(de_excp), 64'(head[64]));
    end
    if (fl) begin
      sb.delete();
    end else begin
      enq = fv && exp_rdy && !(byp && dr);
      deq = exp_vld && dr && !byp;
      if (deq) void'(sb.pop_front());
      if (enq) sb.push_back({fe, fp, fi});
    end
    mcnt = sb.size();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fetch_vld = 1'b0; fetch_inst = 32'h0;
    fetch_pc = 32'h0; fetch_excp = 1'b0; de_rdy = 1'b0;
    #2;
    check("rst_de_vld", 64'(de_vld), 64'h0);
    check("rst_de_inst", 64'(de_inst), 64'h0);
    check("rst_de_pc", 64'(de_pc), 64'h0);
    check("rst_de_excp", 64'(de_excp), 64'h0);
    check("rst_fetch_rdy", 64'(fetch_rdy), 64'h1);
    check("rst_ibuf_cnt", 64'(ibuf_cnt), 64'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Fill to DEPTH with decode stalled, try a fifth push, then drain in order.
    for (int k = 0; k < 4; k++) step(1'b1, 32'(k + 1), 32'h1c000000 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5, 32'h1c000010, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Wrap-around stream with one exception-tagged entry.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h100 + 32'(i), 32'h1c001000 + 32'(4 * i), (i == 5), (i % 3 != 0), 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Simultaneous enq+deq at cnt=2, then at full.
    step(1'b1, 32'h201, 32'h1c002000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h202, 32'h1c002004, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h203, 32'h1c002008, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h204, 32'h1c00200c, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h205, 32'h1c002010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h206, 32'h1c002014, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush at cnt=3 with a competing fetch; next cycle accepts a fresh one.
    step(1'b1, 32'hdeadbeef, 32'h1c00dead, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h301, 32'h1c003000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Empty buffer, decode ready: bypass timing depends on build configuration.
    step(1'b1, 32'h02800421, 32'h1c004000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream at cnt=3.
    for (int k = 0; k < 3; k++) step(1'b1, 32'h400 + 32'(k), 32'h1c005000 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    fetch_vld = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_de_vld", 64'(de_vld), 64'h0);
    check("mid_rst_ibuf_cnt", 64'(ibuf_cnt), 64'h0);
    check("mid_rst_fetch_rdy", 64'(fetch_rdy), 64'h1);
    check("mid_rst_de_inst", 64'(de_inst), 64'h0);
    sb.delete();
    mcnt = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
